// File: rtl/pixel_pack_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pack_ctrl_pkg
// Shared video definitions for the pixel packer: the packing FSM state
// encoding and the default fill value for an unpaired upper half-word.
// No ports; imported by the packer and its sync helper.
// ---------------------------------------------------------------------------
package pixel_pack_ctrl_pkg;

    // Packing FSM states. LOW means the low half is free and the next pixel
    // starts a new word; HIGH means a low half is pending and the next pixel
    // completes the word.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_LOW       = 2'd2,
        ST_HIGH      = 2'd3
    } pack_state_t;

    // Fill value placed in the upper half of a word closing an odd line.
    localparam int unsigned PAD_VAL_DEFAULT = 0;

endpackage : pixel_pack_ctrl_pkg

// File: rtl/pixel_pack_ctrl_sync_edge_dly.sv
// ---------------------------------------------------------------------------
// sync_edge_dly
// One-cycle delay of a sync strobe plus rising-edge detection. The delayed
// copy doubles as the edge reference, so the edge and the delayed output
// always agree with each other.
//
// Ports:
//   clk       in   pixel clock
//   rst       in   asynchronous, active-high reset
//   sync_in   in   raw sync input
//   sync_dly  out  sync_in delayed by one clock
//   sync_rise out  high in the cycle where sync_in rises (combinational)
// ---------------------------------------------------------------------------
module sync_edge_dly (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic sync_dly,
    output logic sync_rise
);

    // Registered copy of the sync; cleared in reset so a sync already high
    // at release is seen as a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_dly <= 1'b0;
        end else begin
            sync_dly <= sync_in;
        end
    end

    // Rising edge: high now, low last cycle.
    assign sync_rise = sync_in & ~sync_dly;

endmodule : sync_edge_dly

// File: rtl/pixel_pack_ctrl.sv
// ---------------------------------------------------------------------------
// pixel_pack_ctrl
// Packs pairs of PIX_W-bit pixels into 2*PIX_W-bit words (first pixel in the
// low half). Odd lines are closed with a padded word. Packing is gated by
// I_en, which only takes effect at a vsync rising edge (frame start). Also
// reports per-line pixel counts, lines per frame, and a sticky error when a
// frame starts in the middle of active video.
//
// Ports:
//   I_clk, I_rst           clock, asynchronous active-high reset
//   I_en                   packing enable, sampled at frame start only
//   I_err_clr              clears O_err (an error in the same cycle wins)
//   I_pixel_data           input pixel
//   I_hsync/I_vsync/I_de   input timing
//   O_pixel_data           packed word, meaningful while O_valid=1
//   O_valid                one-cycle word strobe
//   O_pad                  word's upper half is the PAD_VAL fill
//   O_hsync/O_vsync        timing delayed by one cycle
//   O_line_pix             pixel count of the last completed line
//   O_line_cnt             lines completed in the current frame
//   O_active               FSM is not in IDLE
//   O_err                  sticky protocol error
// ---------------------------------------------------------------------------
module pixel_pack_ctrl
    import pixel_pack_ctrl_pkg::*;
#(
    parameter int          PIX_W   = 24,
    parameter int          CNT_W   = 13,
    parameter int unsigned PAD_VAL = PAD_VAL_DEFAULT
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_en,
    input  logic               I_err_clr,
    input  logic [PIX_W-1:0]   I_pixel_data,
    input  logic               I_hsync,
    input  logic               I_vsync,
    input  logic               I_de,
    output logic [2*PIX_W-1:0] O_pixel_data,
    output logic               O_valid,
    output logic               O_pad,
    output logic               O_hsync,
    output logic               O_vsync,
    output logic [CNT_W-1:0]   O_line_pix,
    output logic [CNT_W-1:0]   O_line_cnt,
    output logic               O_active,
    output logic               O_err
);

    localparam logic [PIX_W-1:0] PAD_HALF = PIX_W'(PAD_VAL);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pack_state_t      state;
    logic [PIX_W-1:0] low_half;
    logic [CNT_W-1:0] pix_cnt;
    logic             frame_start;
    logic             hsync_rise_unused;

    sync_edge_dly u_vsync (
        .clk       (I_clk),
        .rst       (I_rst),
        .sync_in   (I_vsync),
        .sync_dly  (O_vsync),
        .sync_rise (frame_start)
    );

    sync_edge_dly u_hsync (
        .clk       (I_clk),
        .rst       (I_rst),
        .sync_in   (I_hsync),
        .sync_dly  (O_hsync),
        .sync_rise (hsync_rise_unused)
    );

    // Packing FSM with registered outputs. Frame start takes priority over
    // all line handling: it clears the line count, flushes a pending low half
    // as a padded word, flags an error if video was still active, and picks
    // the next state from I_en. O_err is cleared first and set afterwards so
    // a coincident error overrides the clear. O_pixel_data holds its last
    // value between strobes.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state        <= ST_IDLE;
            low_half     <= '0;
            pix_cnt      <= '0;
            O_pixel_data <= '0;
            O_valid      <= 1'b0;
            O_pad        <= 1'b0;
            O_line_pix   <= '0;
            O_line_cnt   <= '0;
            O_active     <= 1'b0;
            O_err        <= 1'b0;
        end else begin
            O_valid <= 1'b0;
            O_pad   <= 1'b0;
            if (I_err_clr) begin
                O_err <= 1'b0;
            end

            if (frame_start) begin
                O_line_cnt <= '0;
                if (state == ST_HIGH) begin
                    O_pixel_data <= {PAD_HALF, low_half};
                    O_valid      <= 1'b1;
                    O_pad        <= 1'b1;
                end
                if (state != ST_IDLE && I_de) begin
                    O_err <= 1'b1;
                end
                state    <= I_en ? ST_WAIT_LINE : ST_IDLE;
                O_active <= I_en;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_WAIT_LINE: begin
                        if (I_de) begin
                            low_half <= I_pixel_data;
                            pix_cnt  <= CNT_ONE;
                            state    <= ST_HIGH;
                        end
                    end
                    ST_LOW: begin
                        if (I_de) begin
                            low_half <= I_pixel_data;
                            pix_cnt  <= (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + CNT_ONE;
                            state    <= ST_HIGH;
                        end else begin
                            O_line_pix <= pix_cnt;
                            O_line_cnt <= (O_line_cnt == CNT_MAX) ? O_line_cnt : O_line_cnt + CNT_ONE;
                            state      <= ST_WAIT_LINE;
                        end
                    end
                    ST_HIGH: begin
                        O_valid <= 1'b1;
                        if (I_de) begin
                            O_pixel_data <= {I_pixel_data, low_half};
                            pix_cnt      <= (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + CNT_ONE;
                            state        <= ST_LOW;
                        end else begin
                            O_pixel_data <= {PAD_HALF, low_half};
                            O_pad        <= 1'b1;
                            O_line_pix   <= pix_cnt;
                            O_line_cnt   <= (O_line_cnt == CNT_MAX) ? O_line_cnt : O_line_cnt + CNT_ONE;
                            state        <= ST_WAIT_LINE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : pixel_pack_ctrl

// File: tb/tb_pixel_pack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pixel_pack_ctrl
// Self-checking bench for pixel_pack_ctrl with CNT_W=3 so counter
// saturation is reachable with short lines. Expected words are queued as
// pixels are driven and compared whenever the DUT strobes O_valid.
// ---------------------------------------------------------------------------
module tb_pixel_pack_ctrl;

    localparam int PIX_W = 24;
    localparam int CNT_W = 3;
    localparam logic [PIX_W-1:0] PAD = '0;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               en = 1'b0;
    logic               errClr = 1'b0;
    logic [PIX_W-1:0]   pixIn = '0;
    logic               hsIn = 1'b0;
    logic               vsIn = 1'b0;
    logic               deIn = 1'b0;
    logic [2*PIX_W-1:0] pixOut;
    logic               validOut;
    logic               padOut;
    logic               hsOut;
    logic               vsOut;
    logic [CNT_W-1:0]   linePix;
    logic [CNT_W-1:0]   lineCnt;
    logic               activeOut;
    logic               errOut;

    int checks = 0;
    int errors = 0;

    // Expected {pad, word} entries in emission order.
    logic [2*PIX_W:0] sb[$];

    typedef struct {
        int               nPix;
        logic [PIX_W-1:0] first;
        int               expLinePix;
        int               expLineCnt;
    } lineVec_t;

    lineVec_t lines[9];

    pixel_pack_ctrl #(
        .PIX_W   (PIX_W),
        .CNT_W   (CNT_W),
        .PAD_VAL (0)
    ) dut (
        .I_clk        (clock),
        .I_rst        (reset),
        .I_en         (en),
        .I_err_clr    (errClr),
        .I_pixel_data (pixIn),
        .I_hsync      (hsIn),
        .I_vsync      (vsIn),
        .I_de         (deIn),
        .O_pixel_data (pixOut),
        .O_valid      (validOut),
        .O_pad        (padOut),
        .O_hsync      (hsOut),
        .O_vsync      (vsOut),
        .O_line_pix   (linePix),
        .O_line_cnt   (lineCnt),
        .O_active     (activeOut),
        .O_err        (errOut)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Hard time limit so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard: every strobe must match the oldest queued word.
    always @(negedge clock) begin
        if (validOut) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_word: got 0x%0h pad %0b expected no word", pixOut, padOut);
            end else begin
                logic [2*PIX_W:0] exp;
                exp = sb.pop_front();
                if ({padOut, pixOut} !== exp) begin
                    errors++;
                    $display("[TB] FAIL word: got pad %0b 0x%0h expected pad %0b 0x%0h",
                             padOut, pixOut, exp[2*PIX_W], exp[2*PIX_W-1:0]);
                end
            end
        end
    end

    // Drive one cycle of timing/pixel inputs, return 1 time unit after the
    // edge that sampled them.
    task automatic applyStimulus(input logic de, input logic [PIX_W-1:0] pix,
                                 input logic hs, input logic vs);
        deIn  = de;
        pixIn = pix;
        hsIn  = hs;
        vsIn  = vs;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic vsyncPulse();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    // One line: hsync pulse, nPix consecutive pixels starting at first, then
    // blanking. When expectWords is set the expected words are queued and
    // the one-cycle strobe latency is checked on every pixel.
    task automatic driveLine(input int nPix, input logic [PIX_W-1:0] first, input bit expectWords);
        logic [PIX_W-1:0] p;
        logic [PIX_W-1:0] prev;
        prev = '0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < nPix; i++) begin
            p = first + PIX_W'(i);
            if (expectWords) begin
                if (i % 2 == 1) sb.push_back({1'b0, p, prev});
                else if (i == nPix - 1) sb.push_back({1'b1, PAD, p});
            end
            applyStimulus(1'b1, p, 1'b0, 1'b0);
            if (expectWords) checkOutput("valid_latency", 64'(validOut), 64'(i % 2 == 1));
            prev = p;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        lines[0] = '{4, 24'h000001, 4, 1};
        lines[1] = '{3, 24'h00000A, 3, 2};
        lines[2] = '{1, 24'h000055, 1, 3};
        lines[3] = '{2, 24'h000010, 2, 4};
        lines[4] = '{10, 24'h000100, 7, 5};
        lines[5] = '{5, 24'h000200, 5, 6};
        lines[6] = '{6, 24'h000300, 6, 7};
        lines[7] = '{7, 24'h000400, 7, 7};
        lines[8] = '{8, 24'h000500, 7, 7};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_valid", 64'(validOut), 0);
        checkOutput("rst_data", 64'(pixOut), 0);
        checkOutput("rst_active", 64'(activeOut), 0);
        checkOutput("rst_line_cnt", 64'(lineCnt), 0);
        checkOutput("rst_err", 64'(errOut), 0);
        reset = 1'b0;
        en = 1'b1;

        // Frame with the line table: even/odd lines and saturation
        checkOutput("vsync_dly_pre", 64'(vsOut), 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("vsync_dly", 64'(vsOut), 1);
        checkOutput("active_frame", 64'(activeOut), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("vsync_dly_fall", 64'(vsOut), 0);
        checkOutput("hsync_dly_pre", 64'(hsOut), 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("hsync_dly", 64'(hsOut), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("hsync_dly_fall", 64'(hsOut), 0);
        for (int k = 0; k < 9; k++) begin
            driveLine(lines[k].nPix, lines[k].first, 1'b1);
            checkOutput("line_pix", 64'(linePix), 64'(lines[k].expLinePix));
            checkOutput("line_cnt", 64'(lineCnt), 64'(lines[k].expLineCnt));
        end
        checkOutput("sb_drain_table", 64'(sb.size()), 0);

        // Gating: disable at frame start, enable mid-frame is ignored
        en = 1'b0;
        vsyncPulse();
        checkOutput("gate_idle", 64'(activeOut), 0);
        checkOutput("gate_cnt_clr", 64'(lineCnt), 0);
        en = 1'b1;
        driveLine(4, 24'h000600, 1'b0);
        checkOutput("gate_still_idle", 64'(activeOut), 0);
        checkOutput("gate_pix_held", 64'(linePix), 7);
        checkOutput("gate_cnt_held", 64'(lineCnt), 0);
        vsyncPulse();
        checkOutput("gate_active", 64'(activeOut), 1);
        driveLine(2, 24'h000700, 1'b1);
        checkOutput("gate_cnt1", 64'(lineCnt), 1);
        en = 1'b0;
        driveLine(3, 24'h000800, 1'b1);
        checkOutput("gate_pix3", 64'(linePix), 3);
        checkOutput("gate_cnt2", 64'(lineCnt), 2);
        checkOutput("gate_active_mid", 64'(activeOut), 1);
        vsyncPulse();
        checkOutput("gate_off", 64'(activeOut), 0);
        checkOutput("sb_drain_gate", 64'(sb.size()), 0);

        // Error: frame start during active video flushes a padded word
        en = 1'b1;
        vsyncPulse();
        applyStimulus(1'b1, 24'h000900, 1'b0, 1'b0);
        sb.push_back({1'b1, PAD, 24'h000900});
        applyStimulus(1'b1, 24'h000901, 1'b0, 1'b1);
        checkOutput("err_set", 64'(errOut), 1);
        checkOutput("err_flush_valid", 64'(validOut), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("err_cnt_clr", 64'(lineCnt), 0);
        errClr = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        errClr = 1'b0;
        checkOutput("err_clr", 64'(errOut), 0);
        applyStimulus(1'b1, 24'h000A00, 1'b0, 1'b0);
        sb.push_back({1'b1, PAD, 24'h000A00});
        errClr = 1'b1;
        applyStimulus(1'b1, 24'h000A01, 1'b0, 1'b1);
        errClr = 1'b0;
        checkOutput("err_set_wins", 64'(errOut), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("sb_drain_err", 64'(sb.size()), 0);

        // Reset mid-line: pending half discarded, outputs cleared at once
        driveLine(3, 24'h000E00, 1'b1);
        applyStimulus(1'b1, 24'h000B00, 1'b0, 1'b0);
        deIn  = 1'b1;
        pixIn = 24'h000B01;
        reset = 1'b1;
        #2;
        checkOutput("rstmid_valid", 64'(validOut), 0);
        checkOutput("rstmid_data", 64'(pixOut), 0);
        checkOutput("rstmid_active", 64'(activeOut), 0);
        checkOutput("rstmid_err", 64'(errOut), 0);
        checkOutput("rstmid_line_pix", 64'(linePix), 0);
        checkOutput("rstmid_line_cnt", 64'(lineCnt), 0);
        applyStimulus(1'b1, 24'h000B02, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        driveLine(4, 24'h000C00, 1'b0);
        checkOutput("rstrel_idle", 64'(activeOut), 0);
        checkOutput("rstrel_line_cnt", 64'(lineCnt), 0);
        vsyncPulse();
        checkOutput("rstrel_active", 64'(activeOut), 1);
        driveLine(2, 24'h000D00, 1'b1);
        checkOutput("rstrel_line_pix", 64'(linePix), 2);
        checkOutput("rstrel_line_cnt1", 64'(lineCnt), 1);
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("sb_drain_end", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pixel_pack_ctrl
